// File: rtl/rom_rd_ctrl_pkg.sv
// rom_rd_ctrl_pkg: shared ROM geometry and read-controller state type
package rom_rd_ctrl_pkg;
  localparam int ROM_ADDR_WIDTH = 8;
  localparam int ROM_DATA_WIDTH = 8;
  localparam int NUM_VLD_ROM_DATA = 21;
  typedef enum logic [1:0] {IDLE, ADDR, PUSH, DONE} rom_rd_state_t;
endpackage

// File: rtl/rom_rd_ctrl_if.sv
// rom_rd_ctrl_if: async ROM strobes/address plus the downstream word stream
interface rom_rd_ctrl_if;
  import rom_rd_ctrl_pkg::*;
  logic [ROM_ADDR_WIDTH-1:0] rom_rd_addr;
  logic                      CE_bar;
  logic                      OE_bar;
  logic                      WE_bar;
  logic [ROM_DATA_WIDTH-1:0] rom_rd_data;
  logic                      out_vld;
  logic [ROM_DATA_WIDTH-1:0] out_data;
  logic                      out_last;
  logic                      out_rdy;
  logic                      load_done;
  modport master (
    output rom_rd_addr, CE_bar, OE_bar, WE_bar, out_vld, out_data, out_last, load_done,
    input  rom_rd_data, out_rdy
  );
  modport slave (
    input  rom_rd_addr, CE_bar, OE_bar, WE_bar, out_vld, out_data, out_last, load_done,
    output rom_rd_data, out_rdy
  );
endinterface

// File: rtl/rom_rd_ctrl.sv
// rom_rd_ctrl: reads ROM words 0..NUM_WORDS-1 with fixed-latency strobes and streams them out
module rom_rd_ctrl
  import rom_rd_ctrl_pkg::*;
#(
  parameter int NUM_WORDS = NUM_VLD_ROM_DATA,
  parameter int RD_LAT    = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  rom_rd_ctrl_if.master bus
);
  localparam int LW = $clog2(RD_LAT + 1);
  localparam logic [LW-1:0] LAT_END = LW'(RD_LAT - 1);
  localparam logic [ROM_ADDR_WIDTH-1:0] ADDR_LAST = ROM_ADDR_WIDTH'(NUM_WORDS - 1);
  rom_rd_state_t             state_q, state_d;
  logic [ROM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LW-1:0]             lat_q, lat_d;
  logic                      stb_n_q, stb_n_d;
  logic                      vld_q, vld_d;
  logic [ROM_DATA_WIDTH-1:0] data_q, data_d;
  logic                      last_q, last_d;
  logic                      done_q, done_d;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lat_q   <= '0;
      stb_n_q <= 1'b1;
      vld_q   <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      stb_n_q <= stb_n_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    stb_n_d = stb_n_q;
    vld_d   = vld_q;
    data_d  = data_q;
    last_d  = last_q;
    done_d  = done_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = ADDR;
        addr_d  = '0;
        lat_d   = '0;
        stb_n_d = 1'b0;
        done_d  = 1'b0;
      end
      ADDR: if (lat_q == LAT_END) begin
        data_d  = bus.rom_rd_data;
        last_d  = addr_q == ADDR_LAST;
        vld_d   = 1'b1;
        stb_n_d = 1'b1;
        state_d = PUSH;
      end else begin
        lat_d = lat_q + 1'b1;
      end
      PUSH: if (bus.out_rdy) begin
        vld_d = 1'b0;
        if (last_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ADDR;
          addr_d  = addr_q + 1'b1;
          lat_d   = '0;
          stb_n_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.rom_rd_addr = addr_q;
  assign bus.CE_bar      = stb_n_q;
  assign bus.OE_bar      = stb_n_q;
  assign bus.WE_bar      = 1'b1;
  assign bus.out_vld     = vld_q;
  assign bus.out_data    = data_q;
  assign bus.out_last    = last_q;
  assign bus.load_done   = done_q;
endmodule

// File: tb/tb_rom_rd_ctrl.sv
// tb_rom_rd_ctrl: randomized scenario tasks plus a per-cycle protocol/scoreboard monitor
module tb_rom_rd_ctrl;
  localparam int NW = 21;
  localparam int RL = 2;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  int checks = 0;
  int errors = 0;
  int beats = 0;
  int loads = 0;
  int beat_idx = 0;
  int run = 0;
  logic [7:0] prev_addr = '0;
  logic [7:0] pd = '0;
  logic pv = 1'b0;
  logic pr = 1'b0;
  logic pl = 1'b0;
  rom_rd_ctrl_if bus ();
  rom_rd_ctrl #(.NUM_WORDS(NW), .RD_LAT(RL)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.rom_rd_data = (!bus.CE_bar && !bus.OE_bar) ? (bus.rom_rd_addr ^ 8'hA5) : 8'h00;
  // Word n of every load must be n ^ 8'hA5, accepted in order, last only on word NW-1.
  always @(negedge clk) begin
    if (!reset_n) begin
      run = 0;
      beat_idx = 0;
      pv = 1'b0;
    end else begin
      checks++;
      if (bus.WE_bar !== 1'b1 || bus.OE_bar !== bus.CE_bar) begin
        errors++;
        $display("FAIL strobes: WE_bar=%b OE_bar=%b CE_bar=%b, want WE_bar=1 OE_bar=CE_bar", bus.WE_bar, bus.OE_bar, bus.CE_bar);
      end
      if (bus.CE_bar === 1'b0) begin
        if (run > 0) begin
          checks++;
          if (bus.rom_rd_addr !== prev_addr) begin
            errors++;
            $display("FAIL addr_stable: addr=%0d while CE low, want %0d", bus.rom_rd_addr, prev_addr);
          end
        end
        run++;
        prev_addr = bus.rom_rd_addr;
      end else if (run > 0) begin
        checks++;
        if (run != RL) begin
          errors++;
          $display("FAIL ce_width: CE_bar low %0d cycles, want %0d", run, RL);
        end
        run = 0;
      end
      if (pv && !pr) begin
        checks++;
        if (bus.out_vld !== 1'b1 || bus.out_data !== pd || bus.out_last !== pl) begin
          errors++;
          $display("FAIL stall_hold: vld=%b data=%h last=%b, want vld=1 data=%h last=%b", bus.out_vld, bus.out_data, bus.out_last, pd, pl);
        end
      end
      if (bus.out_vld === 1'b1 && bus.out_rdy === 1'b1) begin
        checks++;
        if (bus.out_data !== (8'(beat_idx) ^ 8'hA5) || bus.out_last !== (beat_idx == NW - 1) || bus.rom_rd_addr !== 8'(beat_idx)) begin
          errors++;
          $display("FAIL beat: data=%h last=%b addr=%0d, want data=%h last=%b addr=%0d", bus.out_data, bus.out_last, bus.rom_rd_addr, 8'(beat_idx) ^ 8'hA5, beat_idx == NW - 1, beat_idx);
        end
        beats++;
        if (beat_idx == NW - 1) begin
          loads++;
          beat_idx = 0;
        end else begin
          beat_idx++;
        end
      end
      pv = bus.out_vld;
      pr = bus.out_rdy;
      pd = bus.out_data;
      pl = bus.out_last;
    end
  end
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic count_to_done(output int n, input bit rnd_rdy, input bit rnd_start);
    n = 0;
    while (bus.load_done !== 1'b1 && n < 3000) begin
      if (rnd_rdy) bus.out_rdy = 1'($urandom_range(0, 1));
      if (rnd_start) start = 1'($urandom_range(0, 1));
      cyc();
      n++;
    end
    start = 1'b0;
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0;
    bus.out_rdy = 1'b0;
    repeat (3) cyc();
    checks++;
    if ({bus.CE_bar, bus.OE_bar, bus.WE_bar, bus.out_vld, bus.out_last, bus.load_done} !== 6'b111000 || bus.rom_rd_addr !== 8'h00 || bus.out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_vals: ce=%b oe=%b we=%b vld=%b last=%b done=%b addr=%h data=%h, want 1 1 1 0 0 0 00 00", bus.CE_bar, bus.OE_bar, bus.WE_bar, bus.out_vld, bus.out_last, bus.load_done, bus.rom_rd_addr, bus.out_data);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.out_rdy = 1'($urandom_range(0, 1));
      cyc();
      checks++;
      if ({bus.CE_bar, bus.OE_bar, bus.WE_bar, bus.out_vld, bus.load_done} !== 5'b11100) begin
        errors++;
        $display("FAIL idle: ce=%b oe=%b we=%b vld=%b done=%b, want 1 1 1 0 0", bus.CE_bar, bus.OE_bar, bus.WE_bar, bus.out_vld, bus.load_done);
      end
    end
  endtask
  task automatic test_full_load();
    int n, b0, l0;
    b0 = beats;
    l0 = loads;
    bus.out_rdy = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (bus.CE_bar !== 1'b0 || bus.rom_rd_addr !== 8'h00 || bus.load_done !== 1'b0) begin
      errors++;
      $display("FAIL load_start: ce=%b addr=%0d done=%b, want 0 0 0", bus.CE_bar, bus.rom_rd_addr, bus.load_done);
    end
    count_to_done(n, 1'b0, 1'b0);
    checks++;
    if (n != NW * (RL + 1)) begin
      errors++;
      $display("FAIL done_latency: %0d cycles, want %0d", n, NW * (RL + 1));
    end
    checks++;
    if (beats - b0 != NW || loads - l0 != 1) begin
      errors++;
      $display("FAIL full_count: beats=%0d loads=%0d, want %0d 1", beats - b0, loads - l0, NW);
    end
  endtask
  task automatic test_stall();
    int n, b0, l0;
    b0 = beats;
    l0 = loads;
    bus.out_rdy = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    n = 0;
    while (!(bus.out_vld === 1'b1 && bus.rom_rd_addr === 8'd5) && n < 200) begin
      cyc();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL stall_reach: word 5 not presented within %0d cycles", n);
    end
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if (bus.out_vld !== 1'b1 || bus.out_data !== 8'hA0 || bus.CE_bar !== 1'b1 || bus.rom_rd_addr !== 8'd5) begin
        errors++;
        $display("FAIL stall_word5: vld=%b data=%h ce=%b addr=%0d, want 1 a0 1 5", bus.out_vld, bus.out_data, bus.CE_bar, bus.rom_rd_addr);
      end
    end
    bus.out_rdy = 1'b1;
    cyc();
    checks++;
    if (bus.out_vld !== 1'b0 || bus.rom_rd_addr !== 8'd6 || bus.CE_bar !== 1'b0) begin
      errors++;
      $display("FAIL stall_resume: vld=%b addr=%0d ce=%b, want 0 6 0", bus.out_vld, bus.rom_rd_addr, bus.CE_bar);
    end
    count_to_done(n, 1'b1, 1'b0);
    checks++;
    if (n >= 3000 || beats - b0 != NW || loads - l0 != 1) begin
      errors++;
      $display("FAIL stall_count: cycles=%0d beats=%0d loads=%0d, want <3000 %0d 1", n, beats - b0, loads - l0, NW);
    end
  endtask
  task automatic test_start_ignored();
    int n, b0, l0;
    b0 = beats;
    l0 = loads;
    bus.out_rdy = 1'b1;
    start = 1'b1;
    cyc();
    count_to_done(n, 1'b0, 1'b1);
    checks++;
    if (n != NW * (RL + 1)) begin
      errors++;
      $display("FAIL ignore_latency: %0d cycles, want %0d", n, NW * (RL + 1));
    end
    repeat (5) cyc();
    checks++;
    if (bus.load_done !== 1'b1 || bus.CE_bar !== 1'b1 || bus.out_vld !== 1'b0) begin
      errors++;
      $display("FAIL done_hold: done=%b ce=%b vld=%b, want 1 1 0", bus.load_done, bus.CE_bar, bus.out_vld);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (bus.load_done !== 1'b0 || bus.CE_bar !== 1'b0 || bus.rom_rd_addr !== 8'h00) begin
      errors++;
      $display("FAIL reload_start: done=%b ce=%b addr=%0d, want 0 0 0", bus.load_done, bus.CE_bar, bus.rom_rd_addr);
    end
    count_to_done(n, 1'b0, 1'b1);
    checks++;
    if (n != NW * (RL + 1) || beats - b0 != 2 * NW || loads - l0 != 2) begin
      errors++;
      $display("FAIL reload: cycles=%0d beats=%0d loads=%0d, want %0d %0d 2", n, beats - b0, loads - l0, NW * (RL + 1), 2 * NW);
    end
  endtask
  task automatic test_reset_midload();
    int n, b0, l0;
    bus.out_rdy = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    n = 0;
    while (!(bus.CE_bar === 1'b0 && bus.rom_rd_addr === 8'd10) && n < 200) begin
      cyc();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL midload_reach: word 10 not addressed within %0d cycles", n);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.CE_bar !== 1'b1 || bus.OE_bar !== 1'b1 || bus.out_vld !== 1'b0 || bus.rom_rd_addr !== 8'h00 || bus.load_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: ce=%b oe=%b vld=%b addr=%0d done=%b, want 1 1 0 0 0", bus.CE_bar, bus.OE_bar, bus.out_vld, bus.rom_rd_addr, bus.load_done);
    end
    repeat (2) cyc();
    reset_n = 1'b1;
    repeat (3) cyc();
    checks++;
    if (bus.CE_bar !== 1'b1 || bus.load_done !== 1'b0 || bus.out_vld !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: ce=%b done=%b vld=%b, want 1 0 0", bus.CE_bar, bus.load_done, bus.out_vld);
    end
    b0 = beats;
    l0 = loads;
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (bus.CE_bar !== 1'b0 || bus.rom_rd_addr !== 8'h00) begin
      errors++;
      $display("FAIL restart_addr: ce=%b addr=%0d, want 0 0", bus.CE_bar, bus.rom_rd_addr);
    end
    count_to_done(n, 1'b1, 1'b0);
    checks++;
    if (n >= 3000 || beats - b0 != NW || loads - l0 != 1) begin
      errors++;
      $display("FAIL restart_count: cycles=%0d beats=%0d loads=%0d, want <3000 %0d 1", n, beats - b0, loads - l0, NW);
    end
  endtask
  task automatic test_random_loads();
    int n, b0, l0;
    b0 = beats;
    l0 = loads;
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(0, 4)) cyc();
      start = 1'b1;
      cyc();
      count_to_done(n, 1'b1, 1'b1);
      checks++;
      if (n >= 3000) begin
        errors++;
        $display("FAIL random_timeout: load %0d not done after %0d cycles", k, n);
      end
    end
    checks++;
    if (beats - b0 != 3 * NW || loads - l0 != 3) begin
      errors++;
      $display("FAIL random_count: beats=%0d loads=%0d, want %0d 3", beats - b0, loads - l0, 3 * NW);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    bus.out_rdy = 1'b0;
    test_reset();
    test_full_load();
    test_stall();
    test_start_ignored();
    test_reset_midload();
    test_random_loads();
    repeat (3) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
